// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder
//   Multi-cycle WIDTH-bit adder. A single 4-bit carry-look-ahead slice is
//   reused once per clock, LSB nibble first, with the inter-nibble carry held
//   in a register. Upstream sees a start/busy/done handshake.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only while idle
//   a, b      in   WIDTH-bit operands, captured on the accepted start edge
//   cin       in   carry-in, captured on the accepted start edge
//   busy      out  high while an addition is in progress
//   done      out  one-cycle completion pulse
//   sum       out  WIDTH-bit result, updated on completion and then held
//   cout      out  unsigned carry-out of the MSB
//   overflow  out  two's-complement signed overflow
// ---------------------------------------------------------------------------

// 4-bit carry-look-ahead slice.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat function of cin, g and p (no internal ripple).
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_seq_adder #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int MSB   = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] work_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic [WIDTH-1:0] work_d;

    // Operand nibble selected by the running index.
    always_comb begin
        nib_a = a_q[idx_q*4 +: 4];
        nib_b = b_q[idx_q*4 +: 4];
    end

    cla u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Working result with the current nibble merged in; on the last ADD cycle
    // this is the complete sum, so it can be loaded into sum_q on that edge.
    always_comb begin
        work_d = work_q;
        work_d[idx_q*4 +: 4] = nib_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        work_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    work_q  <= work_d;
                    carry_q <= nib_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= work_d;
                        cout_q  <= nib_cout;
                        // Same-sign operands producing an opposite-sign sum.
                        ovf_q   <= (a_q[MSB] == b_q[MSB]) && (work_d[MSB] != a_q[MSB]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=16). Expected results are
// pushed to a scoreboard queue when an addition is launched and popped when
// done is observed.
module tb_cla_seq_adder;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int total;
    int bad;
    int ndone;
    int nexp_done;

    // packed {cout, overflow, sum}
    logic [W+1:0] sb_q[$];

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] s;
        logic       ov;
        s  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        return {s[W], ov, s[W-1:0]};
    endfunction

    // Scoreboard side: compare on every done pulse, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && done) chk("busy_and_done", 1, 0);
            if (done) begin
                ndone++;
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    logic [W+1:0] e;
                    e = sb_q.pop_front();
                    chk("sum",      sum,      e[W-1:0]);
                    chk("cout",     cout,     e[W+1]);
                    chk("overflow", overflow, e[W]);
                end
            end
        end
    end

    // Launch one addition, check busy length / done pulse width.
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int nbusy;
        int cyc;
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        sb_q.push_back(model(x, y, ci));
        nexp_done++;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        cyc   = 0;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
        chk("busy_cycles", nbusy, 4);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        logic [W+1:0] e;
        total = 0; bad = 0; ndone = 0; nexp_done = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", {cout, overflow, sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_add(16'h00FF, 16'h0001, 1'b0);
        do_add(16'hFFFF, 16'h0001, 1'b0);
        do_add(16'h7FFF, 16'h0001, 1'b0);
        do_add(16'h8000, 16'h8000, 1'b0);
        do_add(16'hFFFF, 16'hFFFF, 1'b1);
        do_add(16'h0000, 16'h0000, 1'b1);

        // Outputs hold between operations.
        repeat (3) @(negedge clk);
        chk("hold_sum", sum, 16'h0001);
        chk("hold_cout", cout, 0);

        // Start ignored while busy; operand changes after capture ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        sb_q.push_back(model(16'h1234, 16'h1111, 1'b0));
        nexp_done++;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        chk("busy_inflight", busy, 1);
        repeat (12) @(negedge clk);   // any extra done is flagged by the scoreboard
        chk("no_second_busy", busy, 0);
        chk("inflight_sum", sum, 16'h2345);

        // A start after done is accepted again.
        do_add(16'h0101, 16'h0202, 1'b0);

        // Asynchronous reset mid-ADD: no done, outputs cleared at once.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_out", {cout, overflow, sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_no_done", done, 0);
        do_add(16'h0A0A, 16'h0505, 1'b0);

        e = model(16'h0A0A, 16'h0505, 1'b0);
        chk("final_sum", sum, e[W-1:0]);
        chk("sb_empty", sb_q.size(), 0);
        chk("done_count", ndone, nexp_done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
